// File: rtl/note_sequencer_mc.sv
// Multi-channel note sequencer: once per frame it walks every voice channel over a
// shared synchronous ROM, fetching pitch deltas for new notes and stepping envelopes.
module note_sequencer_mc #(
    parameter int         NUM_CH         = 4,
    parameter int         ENV_W          = 9,
    parameter logic [7:0] NOTE_BASE      = 8'h00,
    parameter logic [7:0] INSTR_LEN_BASE = 8'h80,
    parameter logic [7:0] INSTR_VAL_BASE = 8'h84,
    localparam int        CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_frame_stb,
    input  logic                      i_load,
    input  logic [CH_W-1:0]           i_ch,
    input  logic [5:0]                i_pitch,
    input  logic [4:0]                i_duration,
    input  logic [3:0]                i_instrument,
    output logic [32*NUM_CH-1:0]      o_phase_delta,
    output logic [ENV_W*NUM_CH-1:0]   o_envelope,
    output logic [NUM_CH-1:0]         o_ch_done,
    output logic                      o_busy,
    output logic                      o_frame_done,
    output logic                      o_overrun,
    output logic [7:0]                o_rom_addr,
    input  logic [15:0]               i_rom_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_CH_START, S_PITCH_LO, S_PITCH_HI, S_LEN, S_VAL
    } state_t;

    state_t state, state_nxt;
    logic [CH_W-1:0]                ch;
    logic                           last_ch;
    logic [NUM_CH-1:0]              pending, active, ch_done;
    logic [NUM_CH-1:0][5:0]         slot_pitch;
    logic [NUM_CH-1:0][4:0]         slot_dur, dur_cnt;
    logic [NUM_CH-1:0][3:0]         slot_instr, instr, step, len;
    logic [5:0]                     cur_pitch;
    logic [15:0]                    pitch_lo;
    logic [NUM_CH-1:0][31:0]        phase;
    logic [NUM_CH-1:0][ENV_W-1:0]   env;
    logic                           frame_done, overrun;

    function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] idx);
        return w[4*idx +: 4];
    endfunction

    function automatic logic [ENV_W-1:0] env_scale(input logic [3:0] n);
        logic [ENV_W-1:0] e;
        e = '0;
        e[ENV_W-1 -: 4] = n;
        return e;
    endfunction

    function automatic logic [7:0] pitch_addr(input logic [5:0] p);
        return NOTE_BASE + {1'b0, p, 1'b0};
    endfunction

    function automatic logic [7:0] len_addr(input logic [3:0] ins);
        return INSTR_LEN_BASE + {6'd0, ins[3:2]};
    endfunction

    function automatic logic [7:0] val_addr(input logic [3:0] ins, input logic [3:0] s);
        return INSTR_VAL_BASE + {2'd0, ins, s[3:2]};
    endfunction

    assign last_ch = (ch == CH_W'(NUM_CH - 1));

    always_comb begin
        state_nxt  = state;
        o_rom_addr = 8'd0;
        case (state)
            S_IDLE: begin
                if (i_frame_stb) state_nxt = S_CH_START;
            end
            S_CH_START: begin
                if (pending[ch] && slot_dur[ch] != 5'd0) begin
                    o_rom_addr = pitch_addr(slot_pitch[ch]);
                    state_nxt  = S_PITCH_LO;
                end else if (!pending[ch] && active[ch]) begin
                    o_rom_addr = val_addr(instr[ch], step[ch]);
                    state_nxt  = S_VAL;
                end else begin
                    state_nxt = last_ch ? S_IDLE : S_CH_START;
                end
            end
            S_PITCH_LO: begin
                o_rom_addr = pitch_addr(cur_pitch) + 8'd1;
                state_nxt  = S_PITCH_HI;
            end
            S_PITCH_HI: begin
                o_rom_addr = len_addr(instr[ch]);
                state_nxt  = S_LEN;
            end
            S_LEN: begin
                o_rom_addr = val_addr(instr[ch], 4'd0);
                state_nxt  = S_VAL;
            end
            S_VAL: begin
                state_nxt = last_ch ? S_IDLE : S_CH_START;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            ch         <= '0;
            pending    <= '0;
            active     <= '0;
            slot_pitch <= '0;
            slot_dur   <= '0;
            slot_instr <= '0;
            instr      <= '0;
            step       <= '0;
            len        <= '0;
            dur_cnt    <= '0;
            cur_pitch  <= '0;
            pitch_lo   <= '0;
            phase      <= '0;
            env        <= '0;
            ch_done    <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            ch_done    <= '0;
            overrun    <= i_frame_stb && (state != S_IDLE);
            frame_done <= (state != S_IDLE) && (state_nxt == S_IDLE);

            // CH_START is entered either from IDLE (new frame) or as the advance step
            if (state == S_IDLE && i_frame_stb)
                ch <= '0;
            else if (state != S_IDLE && state_nxt == S_CH_START)
                ch <= ch + 1'b1;

            case (state)
                S_CH_START: begin
                    if (pending[ch]) begin
                        pending[ch] <= 1'b0;
                        if (slot_dur[ch] != 5'd0) begin
                            step[ch]    <= 4'd0;
                            dur_cnt[ch] <= slot_dur[ch];
                            instr[ch]   <= slot_instr[ch];
                            cur_pitch   <= slot_pitch[ch];
                        end else begin
                            active[ch]  <= 1'b0;
                            env[ch]     <= '0;
                            ch_done[ch] <= 1'b1;
                        end
                    end else if (!active[ch]) begin
                        env[ch] <= '0;
                    end
                end
                S_PITCH_LO: pitch_lo <= i_rom_data;
                S_PITCH_HI: phase[ch] <= {i_rom_data, pitch_lo};
                S_LEN: begin
                    len[ch]    <= nib(i_rom_data, instr[ch][1:0]);
                    active[ch] <= 1'b1;
                end
                S_VAL: begin
                    env[ch] <= env_scale(nib(i_rom_data, step[ch][1:0]));
                    if (step[ch] < len[ch]) step[ch] <= step[ch] + 4'd1;
                    dur_cnt[ch] <= dur_cnt[ch] - 5'd1;
                    if (dur_cnt[ch] == 5'd1) begin
                        active[ch]  <= 1'b0;
                        ch_done[ch] <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Placed after consumption so a same-cycle load survives into the next frame
            if (i_load && int'(i_ch) < NUM_CH) begin
                pending[i_ch]    <= 1'b1;
                slot_pitch[i_ch] <= i_pitch;
                slot_dur[i_ch]   <= i_duration;
                slot_instr[i_ch] <= i_instrument;
            end
        end
    end

    assign o_phase_delta = phase;
    assign o_envelope    = env;
    assign o_ch_done     = ch_done;
    assign o_busy        = (state != S_IDLE);
    assign o_frame_done  = frame_done;
    assign o_overrun     = overrun;

endmodule

// File: tb/tb_note_sequencer_mc.sv
// Scoreboard bench for note_sequencer_mc: a frame-level reference model predicts each
// frame's ROM address trace, phase deltas, envelopes and completion pulses.
module tb_note_sequencer_mc;
    localparam int NUM_CH = 4;
    localparam int ENV_W  = 9;
    localparam int CH_W   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst, frame_stb, load;
    logic [CH_W-1:0]          ch;
    logic [5:0]               pitch;
    logic [4:0]               duration;
    logic [3:0]               instrument;
    logic [32*NUM_CH-1:0]     phase_delta;
    logic [ENV_W*NUM_CH-1:0]  envelope;
    logic [NUM_CH-1:0]        ch_done;
    logic                     busy, frame_done, overrun;
    logic [7:0]               rom_addr;
    logic [15:0]              rom_data;
    logic [15:0]              rom [256];

    note_sequencer_mc #(.NUM_CH(NUM_CH), .ENV_W(ENV_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_frame_stb(frame_stb), .i_load(load), .i_ch(ch),
        .i_pitch(pitch), .i_duration(duration), .i_instrument(instrument),
        .o_phase_delta(phase_delta), .o_envelope(envelope), .o_ch_done(ch_done),
        .o_busy(busy), .o_frame_done(frame_done), .o_overrun(overrun),
        .o_rom_addr(rom_addr), .i_rom_data(rom_data)
    );

    always @(posedge clk) rom_data <= rom[rom_addr];

    typedef struct packed {
        logic [7:0]                   ncyc;
        logic [39:0][7:0]             trace;
        logic [NUM_CH-1:0][31:0]      phase;
        logic [NUM_CH-1:0][ENV_W-1:0] env;
        logic [NUM_CH-1:0][1:0]       done;
    } exp_t;

    exp_t sb[$];
    int   ov_q;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: pending slots and per-channel note progress
    bit          m_pend[NUM_CH];
    int          m_ppitch[NUM_CH], m_pdur[NUM_CH], m_pinstr[NUM_CH];
    bit          m_act[NUM_CH];
    int          m_step[NUM_CH], m_len[NUM_CH], m_rem[NUM_CH], m_instr[NUM_CH], m_env[NUM_CH];
    logic [31:0] m_phase[NUM_CH];

    function automatic void check(input string name, input logic [319:0] act, input logic [319:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endfunction

    function automatic int nibv(input int word, input int idx);
        return (word >> (4 * idx)) & 15;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_pend[c] = 0; m_ppitch[c] = 0; m_pdur[c] = 0; m_pinstr[c] = 0;
            m_act[c] = 0; m_step[c] = 0; m_len[c] = 0; m_rem[c] = 0;
            m_instr[c] = 0; m_env[c] = 0; m_phase[c] = 32'd0;
        end
    endfunction

    function automatic void model_frame(output exp_t e);
        int n;
        int w;
        bit play;
        e = '0;
        n = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            play = 0;
            if (m_pend[c]) begin
                m_pend[c] = 0;
                if (m_pdur[c] == 0) begin
                    m_act[c] = 0; m_env[c] = 0; e.done[c] = 2'd1;
                    e.trace[n] = 8'd0; n++;
                end else begin
                    m_instr[c] = m_pinstr[c]; m_step[c] = 0; m_rem[c] = m_pdur[c];
                    m_phase[c] = {rom[2*m_ppitch[c]+1], rom[2*m_ppitch[c]]};
                    m_len[c] = nibv(int'(rom[128 + m_instr[c]/4]), m_instr[c] % 4);
                    e.trace[n]   = 8'(2*m_ppitch[c]);
                    e.trace[n+1] = 8'(2*m_ppitch[c] + 1);
                    e.trace[n+2] = 8'(128 + m_instr[c]/4);
                    n += 3;
                    m_act[c] = 1;
                    play = 1;
                end
            end else if (m_act[c]) begin
                play = 1;
            end else begin
                m_env[c] = 0;
                e.trace[n] = 8'd0; n++;
            end
            if (play) begin
                w = 132 + 4*m_instr[c] + m_step[c]/4;
                e.trace[n] = 8'(w); e.trace[n+1] = 8'd0; n += 2;
                m_env[c] = nibv(int'(rom[w]), m_step[c] % 4) << (ENV_W - 4);
                if (m_step[c] < m_len[c]) m_step[c]++;
                m_rem[c]--;
                if (m_rem[c] == 0) begin m_act[c] = 0; e.done[c] = 2'd1; end
            end
            e.phase[c] = m_phase[c];
            e.env[c]   = ENV_W'(m_env[c]);
        end
        e.ncyc = 8'(n);
    endfunction

    task automatic do_load(input int c, input int p, input int d, input int i);
        @(posedge clk); #1;
        load = 1'b1; ch = CH_W'(c); pitch = 6'(p); duration = 5'(d); instrument = 4'(i);
        @(posedge clk); #1;
        load = 1'b0;
        m_pend[c] = 1; m_ppitch[c] = p; m_pdur[c] = d; m_pinstr[c] = i;
    endtask

    task automatic run_frame(input bit ov, output int lat);
        exp_t e;
        model_frame(e);
        sb.push_back(e);
        @(posedge clk); #1 frame_stb = 1'b1;
        @(posedge clk); #1 frame_stb = 1'b0;
        lat = 1;
        if (ov) begin
            @(posedge clk); #1 frame_stb = 1'b1;
            ov_q++;
            @(posedge clk); #1 frame_stb = 1'b0;
            lat = 3;
        end
        @(negedge clk);
        while (!frame_done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!frame_done) begin
            errors++;
            $display("FAIL frame_timeout: no frame_done after %0d cycles", lat);
            void'(sb.pop_back());
        end
        check("frame_latency", 320'(lat), 320'(int'(e.ncyc) + 1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_phase"}, 320'(phase_delta), 320'(0));
        check({tag, "_env"}, 320'(envelope), 320'(0));
        check({tag, "_ctrl"}, 320'({ch_done, busy, frame_done, overrun, rom_addr}), 320'(0));
    endtask

    // Monitor: collects busy-cycle ROM addresses and done pulses, scores at frame_done
    initial begin : monitor
        logic [39:0][7:0]       a_trace;
        logic [NUM_CH-1:0][1:0] a_done;
        int                     a_n;
        exp_t                   e;
        a_trace = '0; a_done = '0; a_n = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                a_trace = '0; a_done = '0; a_n = 0;
            end else begin
                if (busy) begin
                    if (a_n < 40) a_trace[a_n] = rom_addr;
                    a_n++;
                end
                for (int c = 0; c < NUM_CH; c++)
                    if (ch_done[c] && a_done[c] != 2'd3) a_done[c] = a_done[c] + 2'd1;
                if (overrun) begin
                    checks++;
                    if (ov_q == 0) begin
                        errors++;
                        $display("FAIL overrun: got pulse expected none");
                    end else ov_q--;
                end
                if (frame_done) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL frame_done: got pulse expected none");
                    end else begin
                        e = sb.pop_front();
                        check("busy_cycles", 320'(a_n), 320'(e.ncyc));
                        check("rom_trace", 320'(a_trace), 320'(e.trace));
                        check("ch_done", 320'(a_done), 320'(e.done));
                        for (int c = 0; c < NUM_CH; c++) begin
                            check($sformatf("phase_ch%0d", c), 320'(phase_delta[32*c +: 32]), 320'(e.phase[c]));
                            check($sformatf("env_ch%0d", c), 320'(envelope[ENV_W*c +: ENV_W]), 320'(e.env[c]));
                        end
                    end
                    a_trace = '0; a_done = '0; a_n = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int lat;
        int exp_env1[7] = '{480, 384, 256, 128, 128, 128, 0};
        rst = 1'b1; frame_stb = 1'b0; load = 1'b0; ch = '0;
        pitch = '0; duration = '0; instrument = '0; ov_q = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[8'h0A] = 16'h1234; rom[8'h0B] = 16'h0056;
        rom[8'h81] = 16'h0300; rom[8'h9C] = 16'h48CF;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Empty frame: idle channels only
        run_frame(1'b0, lat);
        check("empty_latency", 320'(lat), 320'(NUM_CH + 1));

        // Single note on ch1 with known envelope table
        do_load(1, 5, 6, 6);
        for (int f = 0; f < 7; f++) begin
            run_frame(1'b0, lat);
            check($sformatf("ch1_env_f%0d", f + 1), 320'(envelope[ENV_W*1 +: ENV_W]), 320'(exp_env1[f]));
            if (f == 0) check("ch1_phase", 320'(phase_delta[63:32]), 320'(32'h00561234));
        end

        // All channels start new notes in one frame
        for (int c = 0; c < NUM_CH; c++) do_load(c, 10 + 7*c, 3 + c, 3*c + 1);
        run_frame(1'b0, lat);
        check("full_latency", 320'(lat), 320'(21));

        // Last load wins on ch2
        do_load(2, 3, 2, 9);
        do_load(2, 7, 2, 9);
        run_frame(1'b0, lat);
        check("ch2_phase_p7", 320'(phase_delta[95:64]), 320'({rom[8'h0F], rom[8'h0E]}));

        // Rest on ch3
        do_load(3, 12, 0, 4);
        run_frame(1'b0, lat);

        // Strobe while busy
        do_load(0, 20, 4, 2);
        run_frame(1'b1, lat);

        // Reset mid-walk, then a clean frame from ch0
        do_load(0, 33, 5, 11);
        do_load(1, 40, 5, 12);
        @(posedge clk); #1 frame_stb = 1'b1;
        @(posedge clk); #1 frame_stb = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_all_zero("midreset");
        do_load(0, 17, 3, 5);
        run_frame(1'b0, lat);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 2) == 0)
                    do_load(c, $urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 15));
            run_frame((f % 7) == 3, lat);
        end

        repeat (4) @(negedge clk);
        check("sb_empty", 320'(sb.size()), 320'(0));
        check("overrun_seen", 320'(ov_q), 320'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
